// File: rtl/regfile_wb_port.sv
// rtl/regfile_wb_port.sv - write-buffered register file port with read forwarding
//
// Buffers writeback requests in a small FIFO and drains them into the
// R0-R14 array one per cycle. The two read ports forward from pending
// buffered writes, youngest first. R15 is never stored. Reads of R15
// return the externally supplied PC+8 value.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   wb_valid/wb_ready writeback handshake; WA3/WD3 sampled on accept
//   wr_stall          array write port busy, holds off the drain
//   RA1/RA2 -> RD1/RD2 combinational read ports
//   R15               PC+8 value returned for address 15
//   wb_pending        buffer holds at least one entry
//   wb_drop           one-cycle pulse after an accepted write to R15

module regfile_wb_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] WA3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              wr_stall,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [DATA_W-1:0] R15,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              wb_pending,
  output logic              wb_drop
);

  localparam int NREG  = (1 << ADDR_W) - 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [ADDR_W-1:0] PC_ADDR  = '1;
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] regs     [NREG];
  logic [ADDR_W-1:0] buf_addr [DEPTH];
  logic [DATA_W-1:0] buf_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  logic accept, is_pc, enq, drain;

  assign wb_ready   = (count < FULL_CNT);
  assign wb_pending = (count != '0);
  assign accept     = wb_valid && wb_ready;
  assign is_pc      = (WA3 == PC_ADDR);
  assign enq        = accept && !is_pc;
  assign drain      = wb_pending && !wr_stall;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Walk the buffer oldest to youngest so the youngest match is the one
  // left in v. Entries beyond count are stale and ignored.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    logic [PTR_W-1:0]  idx;
    if (a == PC_ADDR) return R15;
    v   = regs[a];
    idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count) && buf_addr[idx] == a) v = buf_data[idx];
      idx = next_ptr(idx);
    end
    return v;
  endfunction

  always_comb begin
    RD1 = read_port(RA1);
    RD2 = read_port(RA2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      wb_drop <= 1'b0;
    end else begin
      wb_drop <= accept && is_pc;
      if (enq) begin
        buf_addr[wr_ptr] <= WA3;
        buf_data[wr_ptr] <= WD3;
        wr_ptr           <= next_ptr(wr_ptr);
      end
      // Buffered addresses are never R15, so the index stays in range.
      if (drain) begin
        regs[buf_addr[rd_ptr]] <= buf_data[rd_ptr];
        rd_ptr                 <= next_ptr(rd_ptr);
      end
      case ({enq, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/regfile_wb_port.md
Name: regfile_wb_port

Overview:
- Write side of the architectural register file: accepts writeback requests (WA3/WD3) over a valid/ready handshake and buffers them in a small FIFO.
- Drains the FIFO into the 15-entry general register array (R0–R14), one entry per cycle.
- Serves the two read ports (RA1/RA2) with forwarding from pending buffered writes.
- R15 reads return the externally supplied PC+8 value; R15 is never stored here.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 4, register address width.
- DEPTH, 2, write-buffer entries (≥1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wb_valid  input  1  writeback request valid.
- wb_ready  output  1  buffer can accept a request this cycle.
- WA3  input  ADDR_W  writeback destination register.
- WD3  input  DATA_W  writeback data.
- wr_stall  input  1  array write port busy; inhibits drain this cycle.
- RA1  input  ADDR_W  read address, port 1.
- RA2  input  ADDR_W  read address, port 2.
- R15  input  DATA_W  PC+8 value returned for address 15.
- RD1  output  DATA_W  read data, port 1 (combinational).
- RD2  output  DATA_W  read data, port 2 (combinational).
- wb_pending  output  1  buffer non-empty.
- wb_drop  output  1  registered one-cycle pulse: an accepted request targeted R15 and was discarded.

Behaviour:
- Reset (sync, active-high, on clk edge):
  - R0–R14 = 0.
  - FIFO empty: count = 0, rd/wr pointers = 0.
  - wb_drop = 0.
  - Resulting outputs: wb_ready = 1, wb_pending = 0.
  - Reset wins over any concurrent accept or drain; in-flight buffered writes are discarded and never reach the array.
- Handshake:
  - Accept occurs when wb_valid && wb_ready at a rising edge.
  - wb_ready = (count < DEPTH), combinational from count only; no dependence on wb_valid or wr_stall.
  - WA3/WD3 are sampled only on accept.
- R15 target:
  - An accepted request with WA3 = 15 is not enqueued.
  - wb_drop = 1 in the following cycle; count is unchanged by that accept.
- Drain:
  - Each edge with count > 0 and wr_stall = 0 writes the head entry to array[addr] and pops it.
  - Maximum one drain per cycle.
- Count update:
  - Accept (non-R15) with no drain: count + 1.
  - Drain with no accept: count − 1.
  - Accept and drain in the same cycle: count unchanged, FIFO order preserved.
  - Pointers wrap modulo DEPTH.
- Full: count = DEPTH → wb_ready = 0. A drain that cycle does not make ready high until the next cycle.
- Empty: no drain, wb_pending = 0; wr_stall has no effect.
- Read path (each port independent, purely combinational):
  - Address 15 → R15.
  - Else the youngest buffered entry whose addr matches → its data.
  - Else array[addr].
  - Same-cycle incoming writes are not bypassed; an accepted write is visible on RD1/RD2 from the cycle after accept.
  - Two buffered entries to the same register: the younger wins on reads, and drain order leaves the younger value in the array.
- Latency: accept-to-read-visible = 1 cycle; accept-to-array = 1 cycle + stall cycles + queued entries ahead.

Test Plan:
- Reset, then read RA1 = 3, RA2 = 14 with R15 = 0x0000_0108 → RD1 = RD2 = 0, wb_ready = 1, wb_pending = 0. Read RA1 = 15 → RD1 = 0x0000_0108.
- Write R5 = 0xDEAD_BEEF with wr_stall = 0 → RD1 (RA1 = 5) = 0xDEAD_BEEF the next cycle; wb_pending = 1 for one cycle, then 0; array R5 holds the value.
- Hold wr_stall = 1; write R2 = 0x11, then R2 = 0x22 → wb_ready = 0 after the second accept, RD1 (RA1 = 2) = 0x22. Release stall → two drain cycles, final R2 = 0x22, wb_ready returns to 1.
- Back-to-back writes R1 = 1, R2 = 2, R3 = 3 on consecutive cycles with no stall → wb_ready stays 1, count never exceeds 1, all three values read back correctly.
- Write WA3 = 15, WD3 = 0xFFFF_FFFF → wb_drop pulses 1 cycle, wb_pending stays 0, RA1 = 15 still returns R15.
- Fill buffer under stall, assert reset for one cycle → count = 0, wb_ready = 1, targeted registers read 0.
